// File: rtl/dataframe_stream_arbiter_pkg.sv
// rtl/dataframe_stream_arbiter_pkg.sv - shared sizing constants for the dataframe stream arbiter
package dataframe_stream_arbiter_pkg;

   localparam int RFDC_TDATA_WIDTH    = 128;
   localparam int ARB_N_CH            = 8;
   localparam int ARB_MAX_FRAME_BEATS = 1024;
   localparam int FRAME_CNT_WIDTH     = 32;

   // The beat counter must be able to hold the watchdog limit itself.
   function automatic int beat_cnt_width(input int max_beats);
      return $clog2(max_beats + 1);
   endfunction

endpackage

// File: rtl/dataframe_stream_arbiter_rr_priority_picker.sv
// rtl/dataframe_stream_arbiter_rr_priority_picker.sv - combinational round-robin next-grant picker
module rr_priority_picker #(
   parameter int N = 8
) (
   input  logic [N-1:0]          req,
   input  logic [$clog2(N)-1:0]  last_grant,
   output logic [$clog2(N)-1:0]  next_grant,
   output logic                  any_req
);

   localparam int GW = $clog2(N);

   logic          found;
   logic [GW-1:0] idx;

   // Search starts one past the last grant so the previous winner has lowest priority.
   always_comb begin
      found      = 1'b0;
      idx        = '0;
      next_grant = last_grant;
      for (int i = 1; i <= N; i++) begin
         idx = GW'((int'(last_grant) + i) % N);
         if (!found && req[idx]) begin
            next_grant = idx;
            found      = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/dataframe_stream_arbiter.sv
// rtl/dataframe_stream_arbiter.sv - frame-atomic round-robin merge of N dataframe streams
module dataframe_stream_arbiter
   import dataframe_stream_arbiter_pkg::*;
#(
   parameter int N_CH            = ARB_N_CH,
   parameter int TDATA_WIDTH     = RFDC_TDATA_WIDTH,
   parameter int MAX_FRAME_BEATS = ARB_MAX_FRAME_BEATS,
   parameter int FRAME_CNT_WIDTH = dataframe_stream_arbiter_pkg::FRAME_CNT_WIDTH
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [N_CH-1:0]                 CH_ENABLE,
   input  logic [N_CH-1:0]                 S_AXIS_TVALID,
   output logic [N_CH-1:0]                 S_AXIS_TREADY,
   input  logic [N_CH*TDATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [N_CH*TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
   input  logic [N_CH-1:0]                 S_AXIS_TLAST,
   input  logic                            M_AXIS_TREADY,
   output logic                            M_AXIS_TVALID,
   output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
   output logic [TDATA_WIDTH/8-1:0]        M_AXIS_TKEEP,
   output logic                            M_AXIS_TLAST,
   output logic [$clog2(N_CH)-1:0]         GRANT_CH,
   output logic                            GRANT_VALID,
   output logic [FRAME_CNT_WIDTH-1:0]      FRAME_CNT,
   output logic                            ARB_ERROR
);

   localparam int GW = $clog2(N_CH);
   localparam int KW = TDATA_WIDTH / 8;
   localparam int BW = beat_cnt_width(MAX_FRAME_BEATS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_ERROR = 2'd2
   } state_e;

   state_e                     state;
   logic [GW-1:0]              grant_ch;
   logic [GW-1:0]              next_grant;
   logic                       any_req;
   logic [BW-1:0]              beat_cnt;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
   logic                       arb_error;
   logic                       xfer;
   logic                       beat_acc;
   logic [TDATA_WIDTH-1:0]     ch_tdata [N_CH];
   logic [KW-1:0]              ch_tkeep [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign ch_tdata[k] = S_AXIS_TDATA[k*TDATA_WIDTH +: TDATA_WIDTH];
      assign ch_tkeep[k] = S_AXIS_TKEEP[k*KW +: KW];
   end

   rr_priority_picker #(
      .N (N_CH)
   ) u_picker (
      .req        (S_AXIS_TVALID & CH_ENABLE),
      .last_grant (grant_ch),
      .next_grant (next_grant),
      .any_req    (any_req)
   );

   // Only the granted channel is routed; everything else sees TREADY low.
   assign xfer          = (state == ST_XFER);
   assign M_AXIS_TVALID = xfer & S_AXIS_TVALID[grant_ch];
   assign M_AXIS_TDATA  = ch_tdata[grant_ch];
   assign M_AXIS_TKEEP  = ch_tkeep[grant_ch];
   assign M_AXIS_TLAST  = S_AXIS_TLAST[grant_ch];
   assign beat_acc      = M_AXIS_TVALID & M_AXIS_TREADY;

   always_comb begin
      S_AXIS_TREADY = '0;
      if (xfer) begin
         S_AXIS_TREADY[grant_ch] = M_AXIS_TREADY;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         grant_ch  <= GW'(N_CH - 1);
         beat_cnt  <= '0;
         frame_cnt <= '0;
         arb_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  grant_ch <= next_grant;
                  beat_cnt <= '0;
                  state    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + BW'(1);
                  if (M_AXIS_TLAST) begin
                     frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
                     state     <= ST_IDLE;
                  end else if (beat_cnt == BW'(MAX_FRAME_BEATS - 1)) begin
                     // Runaway frame: latch the error and stay quiet until reset.
                     arb_error <= 1'b1;
                     state     <= ST_ERROR;
                  end
               end
            end
            ST_ERROR: begin
               arb_error <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign GRANT_CH    = grant_ch;
   assign GRANT_VALID = xfer;
   assign FRAME_CNT   = frame_cnt;
   assign ARB_ERROR   = arb_error;

endmodule

// File: tb/tb_dataframe_stream_arbiter.sv
// tb/tb_dataframe_stream_arbiter.sv - self-checking bench for dataframe_stream_arbiter
module tb_dataframe_stream_arbiter;

   localparam int N    = 8;
   localparam int W    = 32;
   localparam int KW   = W / 8;
   localparam int MAXB = 8;
   localparam int GW   = 3;
   localparam int QD   = 256;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [N-1:0]      CH_ENABLE;
   logic [N-1:0]      S_AXIS_TVALID;
   logic [N-1:0]      S_AXIS_TREADY;
   logic [N*W-1:0]    S_AXIS_TDATA;
   logic [N*KW-1:0]   S_AXIS_TKEEP;
   logic [N-1:0]      S_AXIS_TLAST;
   logic              M_AXIS_TREADY;
   logic              M_AXIS_TVALID;
   logic [W-1:0]      M_AXIS_TDATA;
   logic [KW-1:0]     M_AXIS_TKEEP;
   logic              M_AXIS_TLAST;
   logic [GW-1:0]     GRANT_CH;
   logic              GRANT_VALID;
   logic [31:0]       FRAME_CNT;
   logic              ARB_ERROR;

   always #5 ACLK = ~ACLK;

   dataframe_stream_arbiter #(
      .N_CH            (N),
      .TDATA_WIDTH     (W),
      .MAX_FRAME_BEATS (MAXB),
      .FRAME_CNT_WIDTH (32)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .CH_ENABLE     (CH_ENABLE),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TKEEP  (S_AXIS_TKEEP),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TKEEP  (M_AXIS_TKEEP),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .GRANT_CH      (GRANT_CH),
      .GRANT_VALID   (GRANT_VALID),
      .FRAME_CNT     (FRAME_CNT),
      .ARB_ERROR     (ARB_ERROR)
   );

   typedef struct packed {
      logic [W-1:0]  data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   // Per-channel source queues as flat arrays with read/write pointers.
   beat_t mem [N][QD];
   int    rd  [N];
   int    wr  [N];

   // Reference model: which channel owns the output, beats in this frame, frames done.
   bit    m_busy;
   bit    m_err;
   int    m_g;
   int    m_beats;
   int    m_frames;

   int    vectors;
   int    miscompares;
   bit    gaps;
   int    rmode;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load(input int ch, input int len, input bit with_last);
      for (int b = 0; b < len; b++) begin
         mem[ch][wr[ch]] = '{data: W'($urandom), keep: KW'($urandom),
                             last: (with_last && b == len - 1)};
         wr[ch]++;
      end
   endtask

   task automatic flush();
      for (int k = 0; k < N; k++) begin
         rd[k] = 0;
         wr[k] = 0;
      end
      S_AXIS_TVALID = '0;
   endtask

   function automatic bit pending();
      for (int k = 0; k < N; k++)
         if (rd[k] != wr[k]) return 1'b1;
      return 1'b0;
   endfunction

   // Called on the falling edge: present the head beat of each queue, holding TVALID once raised.
   task automatic drive();
      beat_t cur;
      for (int k = 0; k < N; k++) begin
         if (rd[k] == wr[k])
            S_AXIS_TVALID[k] = 1'b0;
         else if (!S_AXIS_TVALID[k])
            S_AXIS_TVALID[k] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         cur = mem[k][rd[k]];
         S_AXIS_TDATA[k*W +: W]   = cur.data;
         S_AXIS_TKEEP[k*KW +: KW] = cur.keep;
         S_AXIS_TLAST[k]          = cur.last;
      end
      case (rmode)
         0:       M_AXIS_TREADY = 1'b1;
         1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
         default: M_AXIS_TREADY = ($urandom_range(0, 2) != 0);
      endcase
   endtask

   // Check outputs mid-cycle, then advance model and sources across the rising edge.
   task automatic tick();
      logic [N-1:0] e_trdy;
      logic [N-1:0] req;
      logic         e_tv;
      logic         acc;
      logic         acc_last;
      beat_t        cur;
      #2;
      e_tv     = 1'b0;
      e_trdy   = '0;
      acc_last = 1'b0;
      if (m_busy) begin
         e_tv         = S_AXIS_TVALID[m_g];
         e_trdy[m_g]  = M_AXIS_TREADY;
      end
      chk("m_tvalid", M_AXIS_TVALID, e_tv);
      chk("s_tready", S_AXIS_TREADY, e_trdy);
      chk("grant_valid", GRANT_VALID, m_busy);
      chk("grant_ch", GRANT_CH, m_g);
      chk("frame_cnt", FRAME_CNT, m_frames);
      chk("arb_error", ARB_ERROR, m_err);
      if (e_tv) begin
         cur = mem[m_g][rd[m_g]];
         chk("m_tdata", M_AXIS_TDATA, cur.data);
         chk("m_tkeep", M_AXIS_TKEEP, cur.keep);
         chk("m_tlast", M_AXIS_TLAST, cur.last);
      end
      @(posedge ACLK);
      acc = e_tv && M_AXIS_TREADY;
      if (acc) begin
         acc_last = mem[m_g][rd[m_g]].last;
         rd[m_g]++;
      end
      if (ARESET) begin
         m_busy = 0; m_err = 0; m_g = N - 1; m_beats = 0; m_frames = 0;
      end else if (m_err) begin
         m_busy = 0;
      end else if (!m_busy) begin
         req = S_AXIS_TVALID & CH_ENABLE;
         for (int i = 1; i <= N; i++) begin
            if (!m_busy && req[(m_g + i) % N]) begin
               m_g     = (m_g + i) % N;
               m_busy  = 1;
               m_beats = 0;
            end
         end
      end else if (acc) begin
         m_beats++;
         if (acc_last) begin
            m_frames++;
            m_busy = 0;
         end else if (m_beats == MAXB) begin
            m_err  = 1;
            m_busy = 0;
         end
      end
      @(negedge ACLK);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         tick();
      end
   endtask

   task automatic do_reset();
      flush();
      ARESET = 1'b1;
      run(1);
      ARESET = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (n < bound && (pending() || m_busy)) begin
         run(1);
         n++;
      end
      chk("drain_timeout", (pending() || m_busy), 0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      gaps = 0; rmode = 0;
      m_busy = 0; m_err = 0; m_g = N - 1; m_beats = 0; m_frames = 0;
      for (int k = 0; k < N; k++) begin rd[k] = 0; wr[k] = 0; end
      ARESET = 1'b1;
      CH_ENABLE = '1;
      S_AXIS_TVALID = '0; S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0; S_AXIS_TLAST = '0;
      M_AXIS_TREADY = 1'b1;
      @(negedge ACLK);
      run(2);
      ARESET = 1'b0;

      // Single 4-beat frame on channel 2.
      load(2, 4, 1);
      run(6);
      chk("single_frames", FRAME_CNT, 1);
      chk("single_grant", GRANT_CH, 2);

      // Round robin from reset: channels 0,1,3 with two 3-beat frames each.
      do_reset();
      load(0, 3, 1); load(0, 3, 1);
      load(1, 3, 1); load(1, 3, 1);
      load(3, 3, 1); load(3, 3, 1);
      run(24);
      chk("rr_frames", FRAME_CNT, 6);
      chk("rr_last_grant", GRANT_CH, 3);

      // Backpressure toggling during a channel 5 frame.
      rmode = 1;
      M_AXIS_TREADY = 1'b0;
      load(5, 4, 1);
      run(12);
      chk("bp_frames", FRAME_CNT, 7);
      rmode = 0;

      // Disabled requester is ignored; dropping the active enable mid-frame does not abort.
      CH_ENABLE = 8'b1111_1101;
      load(1, 2, 1);
      run(4);
      chk("mask_tvalid", M_AXIS_TVALID, 0);
      chk("mask_gvalid", GRANT_VALID, 0);
      load(4, 6, 1);
      run(1);
      CH_ENABLE = 8'b1110_1101;
      run(10);
      chk("mask_frames", FRAME_CNT, 8);
      chk("mask_grant", GRANT_CH, 4);
      CH_ENABLE = '1;
      drain(50);
      chk("mask_release", FRAME_CNT, 9);

      // Watchdog: eight beats without TLAST, twice across a reset.
      for (int r = 0; r < 2; r++) begin
         do_reset();
         chk("wd_clear", ARB_ERROR, 0);
         load(0, 10, 0);
         run(10);
         chk("wd_error", ARB_ERROR, 1);
         chk("wd_tready", S_AXIS_TREADY, 0);
      end

      // Reset in the middle of a channel 6 frame.
      do_reset();
      load(6, 6, 1);
      run(3);
      ARESET = 1'b1;
      run(1);
      ARESET = 1'b0;
      chk("rst_tvalid", M_AXIS_TVALID, 0);
      chk("rst_frames", FRAME_CNT, 0);
      chk("rst_grant", GRANT_CH, N - 1);
      load(0, 3, 1);
      run(2);
      chk("rst_first", GRANT_CH, 0);
      drain(50);

      // Randomized traffic with gaps, random ready and changing enables.
      do_reset();
      gaps = 1;
      rmode = 2;
      for (int t = 0; t < 800; t++) begin
         for (int k = 0; k < N; k++) begin
            if (rd[k] == wr[k] && $urandom_range(0, 7) == 0) begin
               rd[k] = 0;
               wr[k] = 0;
               load(k, $urandom_range(1, 6), 1);
            end
         end
         if (t % 50 == 0) CH_ENABLE = N'($urandom) | 8'h01;
         run(1);
      end
      CH_ENABLE = '1;
      drain(1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
